// File: rtl/input_debounce_pulse_pkg.sv
// Shared types and defaults for the input debounce / pulse conditioner.
//   state_t         : debounce FSM encoding (LOW/RISE_CHK/HIGH/FALL_CHK)
//   DEF_SYNC_STAGES : default synchroniser depth
//   DEF_DB_CYCLES   : default number of stable samples to accept a change
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/input_debounce_pulse_if.sv
// Signal bundle between the debounce conditioner and its user.
//   raw_in    : asynchronous raw input (may bounce)
//   en        : pulse enable, gates pulse_out only
//   pulse_out : one-cycle strobe per accepted rising edge
//   level_out : debounced stable level
// slave modport is the conditioner side, master is the user side.
interface input_debounce_pulse_if;

  logic raw_in;
  logic en;
  logic pulse_out;
  logic level_out;

  modport slave (
    input  raw_in,
    input  en,
    output pulse_out,
    output level_out
  );

  modport master (
    output raw_in,
    output en,
    input  pulse_out,
    input  level_out
  );

endinterface

// File: rtl/input_debounce_pulse_sync.sv
// Plain flop chain synchroniser for one asynchronous bit.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
// Nothing sits between stages so the tool can place them as a sync cell.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debounce_pulse.sv
// Synchronise, debounce and edge-detect a raw input.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   dbi   : slave side of input_debounce_pulse_if
//           (raw_in, en in; pulse_out, level_out out)
// One accepted rising edge yields exactly one single-cycle pulse_out,
// coincident with the first cycle level_out reads 1.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   LOW      | stable low, waiting for a 1 sample
//   RISE_CHK | counting consecutive 1 samples towards HIGH
//   HIGH     | stable high, waiting for a 0 sample
//   FALL_CHK | counting consecutive 0 samples towards LOW
module input_debounce_pulse
  import debounce_pkg::*;
#(
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int DB_CYCLES   = DEF_DB_CYCLES,
  localparam int CNT_W       = $clog2(DB_CYCLES)
) (
  input logic                   clk,
  input logic                   rst_n,
  input_debounce_pulse_if.slave dbi
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_last;
  logic             rise_accept;
  logic             pulse_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dbi.raw_in),
    .q    (s)
  );

  assign cnt_last = (cnt == CNT_LAST);

  // The LOW/HIGH entry sample already counts as the first of DB_CYCLES,
  // which is why the check states are entered with cnt = 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      RISE_CHK: begin
        if (!s) begin
          state_nxt = LOW;
        end else if (cnt_last) begin
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      FALL_CHK: begin
        if (s) begin
          state_nxt = HIGH;
        end else if (cnt_last) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
      end
    endcase
  end

  // Pulse is decided on the RISE_CHK->HIGH edge only, so en rising while
  // already HIGH can never produce a late pulse.
  assign rise_accept = (state == RISE_CHK) && s && cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOW;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= rise_accept && dbi.en;
    end
  end

  assign dbi.pulse_out = pulse_q;
  assign dbi.level_out = (state == HIGH) || (state == FALL_CHK);

endmodule

// File: tb/tb_input_debounce_pulse.sv
module tb_input_debounce_pulse;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  input_debounce_pulse_if dbi ();

  input_debounce_pulse #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbi  (dbi)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_q[$];
  int   obs_q[$];
  logic model_clr = 1'b1;
  int   ms = 0;

  // Pulse monitor records the cycle index at which pulse_out was high;
  // also runs a downstream 3-state Moore counter model fed by pulse_out.
  always @(posedge clk) begin
    if (dbi.pulse_out === 1'b1) obs_q.push_back(cyc);
    cyc <= cyc + 1;
    if (model_clr) ms <= 0;
    else if (dbi.pulse_out === 1'b1) ms <= (ms == 2) ? 0 : ms + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Latency: SYNC_STAGES + DB_CYCLES = 6 edges after the input change.
  task automatic expect_pulse();
    exp_q.push_back(cyc + 6);
  endtask

  task automatic compare_pulses(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_cycle"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int exp_ms[3];
    exp_ms[0] = 1; exp_ms[1] = 2; exp_ms[2] = 0;

    // Reset held with input high
    rst_n = 1'b0; dbi.raw_in = 1'b1; dbi.en = 1'b1;
    repeat (3) begin
      cycles(1);
      check("rst_pulse", dbi.pulse_out, 1'b0);
      check("rst_level", dbi.level_out, 1'b0);
    end
    rst_n = 1'b1; expect_pulse();
    cycles(5); check("rel_level_e5", dbi.level_out, 1'b0);
    cycles(1); check("rel_level_e6", dbi.level_out, 1'b1);
               check("rel_pulse_e6", dbi.pulse_out, 1'b1);
    cycles(1); check("rel_pulse_e7", dbi.pulse_out, 1'b0);
    cycles(3); compare_pulses("rel");

    // Clean press and release
    dbi.raw_in = 1'b0; cycles(10);
    check("idle_level", dbi.level_out, 1'b0);
    dbi.raw_in = 1'b1; expect_pulse();
    cycles(5); check("press_level_e5", dbi.level_out, 1'b0);
               check("press_pulse_e5", dbi.pulse_out, 1'b0);
    cycles(1); check("press_level_e6", dbi.level_out, 1'b1);
               check("press_pulse_e6", dbi.pulse_out, 1'b1);
    cycles(1); check("press_pulse_e7", dbi.pulse_out, 1'b0);
    cycles(13); check("press_hold_level", dbi.level_out, 1'b1);
    dbi.raw_in = 1'b0;
    cycles(5); check("fall_level_e5", dbi.level_out, 1'b1);
    cycles(1); check("fall_level_e6", dbi.level_out, 1'b0);
               check("fall_pulse_e6", dbi.pulse_out, 1'b0);
    cycles(5); compare_pulses("press");

    // Bounce 1,0,1,1,0,1,1,1...
    dbi.raw_in = 1'b1; cycles(1);
    dbi.raw_in = 1'b0; cycles(1);
    dbi.raw_in = 1'b1; cycles(2);
    dbi.raw_in = 1'b0; cycles(1);
    dbi.raw_in = 1'b1; expect_pulse();
    cycles(5); check("bounce_level_e5", dbi.level_out, 1'b0);
    cycles(1); check("bounce_level_e6", dbi.level_out, 1'b1);
               check("bounce_pulse_e6", dbi.pulse_out, 1'b1);
    cycles(10); compare_pulses("bounce");

    // Three-cycle glitch must be rejected
    dbi.raw_in = 1'b0; cycles(10);
    dbi.raw_in = 1'b1; cycles(3);
    dbi.raw_in = 1'b0; cycles(10);
    check("glitch_level", dbi.level_out, 1'b0);
    compare_pulses("glitch");

    // Disabled during qualification, enabled later while held high
    dbi.en = 1'b0; dbi.raw_in = 1'b1; cycles(10);
    check("dis_level", dbi.level_out, 1'b1);
    dbi.en = 1'b1; cycles(10);
    check("dis_late_en_level", dbi.level_out, 1'b1);
    compare_pulses("disable");
    dbi.raw_in = 1'b0; cycles(10);
    check("dis_fall_level", dbi.level_out, 1'b0);

    // Reset in RISE_CHK with cnt=2
    dbi.raw_in = 1'b1; cycles(4);
    rst_n = 1'b0; #1;
    check("middb_rst_level", dbi.level_out, 1'b0);
    check("middb_rst_pulse", dbi.pulse_out, 1'b0);
    cycles(3);
    rst_n = 1'b1; expect_pulse();
    cycles(5); check("middb_level_e5", dbi.level_out, 1'b0);
    cycles(1); check("middb_level_e6", dbi.level_out, 1'b1);
               check("middb_pulse_e6", dbi.pulse_out, 1'b1);
    cycles(4); compare_pulses("middb");

    // Reset while pulse is high clears it at once
    dbi.raw_in = 1'b0; cycles(10);
    dbi.raw_in = 1'b1; cycles(6);
    check("midp_pulse_pre", dbi.pulse_out, 1'b1);
    rst_n = 1'b0; #1;
    check("midp_pulse_rst", dbi.pulse_out, 1'b0);
    check("midp_level_rst", dbi.level_out, 1'b0);
    cycles(2);
    dbi.raw_in = 1'b0; rst_n = 1'b1; cycles(10);
    check("midp_level_after", dbi.level_out, 1'b0);
    compare_pulses("midp");

    // Integration with a downstream s0->s1->s2->s0 Moore counter
    model_clr = 1'b1; cycles(1); model_clr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      dbi.raw_in = 1'b1; expect_pulse(); cycles(10);
      check("integ_state", ms, exp_ms[p]);
      check("integ_out", (ms == 2), (p == 1));
      dbi.raw_in = 1'b0; cycles(10);
    end
    compare_pulses("integ");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debounce_pulse.md
Name: input_debounce_pulse

Overview:
- Upstream conditioner for the Moore-FSM input-pulse counter.
- Takes a raw asynchronous input (button or external strobe), synchronises it and debounces it, then emits exactly one single-cycle `pulse_out` per qualified rising edge.
- `pulse_out` drives the counter FSM's `in` directly, so one physical press advances the counter by exactly one state.

Parameters:
- `SYNC_STAGES`, 2, number of synchroniser flops; legal values 2..4.
- `DB_CYCLES`, 4, consecutive synchronised samples needed to accept a level change; must be ≥ 2.
- `CNT_W`, `$clog2(DB_CYCLES)`, debounce counter width; derived, not overridden.

Ports:
- `clk`  input  1  system clock; all flops on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `raw_in`  input  1  asynchronous raw input, may bounce.
- `en`  input  1  pulse enable; 0 suppresses `pulse_out` only.
- `pulse_out`  output  1  one-cycle strobe per accepted rising edge.
- `level_out`  output  1  debounced stable level.

Behaviour:
- **Reset:** `rst_n`=0 immediately clears the following: all sync flops, FSM to `LOW`, counter, `pulse_out`, `level_out`.
  - Deassertion is taken synchronously at the next edge.
  - Reset mid-debounce or mid-pulse discards all progress with no partial pulse.
- **Synchroniser:** `raw_in` passes through `SYNC_STAGES` flops; `s` = last stage. No logic sits between stages.
- **FSM states** (registered, Moore outputs):
  - `LOW`: `level_out`=0.
    - `s`=1 → `RISE_CHK`, cnt←1.
    - Otherwise stay, cnt←0.
  - `RISE_CHK`: `level_out`=0.
    - `s`=0 → `LOW`, cnt←0 (glitch rejected).
    - `s`=1 and cnt==`DB_CYCLES`-1 → `HIGH`, cnt←0.
    - Otherwise cnt←cnt+1.
  - `HIGH`: `level_out`=1.
    - `s`=0 → `FALL_CHK`, cnt←1.
    - Otherwise stay.
  - `FALL_CHK`: `level_out`=1.
    - `s`=1 → `HIGH`, cnt←0.
    - `s`=0 and cnt==`DB_CYCLES`-1 → `LOW`, cnt←0.
    - Otherwise cnt←cnt+1.
  - Illegal encodings → `LOW`.
- **`pulse_out`:**
  - Registered; high for exactly one cycle, on the cycle `level_out` first becomes 1, and only if `en` was 1 on the `RISE_CHK`→`HIGH` transition edge.
  - Never asserted on a falling edge.
  - Never asserted on two consecutive cycles.
- **Latency:** counting the first edge that samples `raw_in`=1 as edge 1, `pulse_out` and `level_out` rise after edge `SYNC_STAGES`+`DB_CYCLES` (edge 6 at defaults). The falling path is symmetric for `level_out`.
- **Qualification:** a level change is accepted only after `DB_CYCLES` consecutive identical `s` samples. Any opposite sample restarts qualification from the stable state.
- **Counter:** never exceeds `DB_CYCLES`-1; no wrap.
- **`en` toggling:** affects only the transition edge. `level_out` tracking continues while `en`=0. A held-high input with `en` rising later produces no pulse.
- **No spurious edges:** input held high indefinitely yields exactly one pulse.

Decomposition:
- Package `debounce_pkg`:
  - `state_t` enum: `LOW`, `RISE_CHK`, `HIGH`, `FALL_CHK`, 2-bit encoding 00/01/10/11.
  - Default constants `DEF_SYNC_STAGES`=2 and `DEF_DB_CYCLES`=4.
- Sub-module `sync_chain` (parameter `STAGES`; ports `clk`, `rst_n`, `d`, `q`), instantiated once. It is reusable for other asynchronous inputs.
- FSM, counter and pulse register stay in the top module.

Test Plan:
1. **Reset:** `rst_n`=0 with `raw_in`=1 held → `pulse_out`=0, `level_out`=0 throughout. Release `rst_n` → single pulse at edge 6 after release, `level_out`=1.
2. **Clean press:** `raw_in` 0→1 held 20 cycles, `en`=1 → `pulse_out`=1 for exactly 1 cycle at edge 6; `level_out` 1 from edge 6. Release → `level_out` 0 at edge 6 after release, no pulse.
3. **Bounce:** `raw_in` pattern 1,0,1,1,0,1,1,1,1,1… → one pulse only, 6 edges after the final 0→1. Glitches of length <4 cycles → no pulse.
4. **Disable:** `en`=0 during qualification, input held high → `level_out`=1, `pulse_out` stays 0. Set `en`=1 later → still no pulse.
5. **Reset mid-debounce:** assert `rst_n`=0 while in `RISE_CHK` with cnt=2 → outputs 0 immediately. After release with input held high → full 6-edge requalification and exactly one pulse.
6. **Integration:** drive `fsm_moore.in` from `pulse_out` with 3 clean presses → counter sequence s0→s1→s2→s0. Its `out`=1 only while in s2.
